cdb_arbiter: RTL and testbench

//  Common Data Bus transmitter: collects completions from NUM_EU execution units, buffers them per EU
//  and broadcasts at most one completion per cycle (valid/prd/rob_tag/result) to every reservation

---
 rtl/cdb_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Common Data Bus transmitter. Completions from NUM_EU execution units are
// buffered per EU in a small FIFO. At most one buffered completion per cycle is
// broadcast to every consumer (reservation stations, PRF, ROB). The buffers are
// served round-robin. On a branch mispredict, completions younger than the
// branch are flushed.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   i_eu_valid[e]       EU e presents a completion
//   i_eu_prd/rob_tag/result  per-EU completion payload (slice e = EU e)
//   o_eu_ready[e]       EU e may present a completion (registered state only)
//   o_cdb_*             registered broadcast: valid, prd, rob_tag, result
//   i_rob_head          tag of the oldest in-flight instruction (age base)
//   branch_mispredict   flush request for this cycle
//   mispredict_rob_tag  tag of the mispredicting branch
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4,
  parameter int NUM_EU     = 3,
  parameter int QDEPTH     = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_EU-1:0]            i_eu_valid,
  input  logic [NUM_EU*PREG_WIDTH-1:0] i_eu_prd,
  input  logic [NUM_EU*ROB_WIDTH-1:0]  i_eu_rob_tag,
  input  logic [NUM_EU*32-1:0]         i_eu_result,
  output logic [NUM_EU-1:0]            o_eu_ready,
  output logic                         o_cdb_valid,
  output logic [PREG_WIDTH-1:0]        o_cdb_prd,
  output logic [ROB_WIDTH-1:0]         o_cdb_rob_tag,
  output logic [31:0]                  o_cdb_result,
  input  logic [ROB_WIDTH-1:0]         i_rob_head,
  input  logic                         branch_mispredict,
  input  logic [ROB_WIDTH-1:0]         mispredict_rob_tag
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int RR_W  = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

  typedef struct packed {
    logic [PREG_WIDTH-1:0] prd;
    logic [ROB_WIDTH-1:0]  rob_tag;
    logic [31:0]           result;
  } cpl_t;

  // Buffer state: validity is reset, payload is not.
  cpl_t              slot_data  [NUM_EU][QDEPTH];
  logic [QDEPTH-1:0] slot_valid [NUM_EU];
  logic [PTR_W-1:0]  head_q     [NUM_EU];
  logic [PTR_W-1:0]  tail_q     [NUM_EU];
  logic [CNT_W-1:0]  count_q    [NUM_EU];
  logic [RR_W-1:0]   rr_q;

  cpl_t              in_cpl     [NUM_EU];
  cpl_t              head_cpl   [NUM_EU];
  logic [NUM_EU-1:0] head_valid;
  logic [NUM_EU-1:0] push;
  logic [NUM_EU-1:0] pop;
  logic              grant;
  logic [RR_W-1:0]   winner;
  cpl_t              win_cpl;
  logic              load;

  // Age relative to the ROB head, so that tags compare correctly across the
  // wrap point of the tag space.
  function automatic logic is_younger(input logic [ROB_WIDTH-1:0] tag,
                                      input logic [ROB_WIDTH-1:0] head,
                                      input logic [ROB_WIDTH-1:0] br_tag);
    logic [ROB_WIDTH-1:0] age_t;
    logic [ROB_WIDTH-1:0] age_b;
    age_t = tag - head;
    age_b = br_tag - head;
    return age_t > age_b;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Per-EU unpacking, handshake and head inspection.
  always_comb begin
    for (int e = 0; e < NUM_EU; e++) begin
      in_cpl[e].prd     = i_eu_prd[e*PREG_WIDTH +: PREG_WIDTH];
      in_cpl[e].rob_tag = i_eu_rob_tag[e*ROB_WIDTH +: ROB_WIDTH];
      in_cpl[e].result  = i_eu_result[e*32 +: 32];
      head_cpl[e]       = slot_data[e][head_q[e]];
      head_valid[e]     = (count_q[e] != '0) && slot_valid[e][head_q[e]];
      o_eu_ready[e]     = (count_q[e] < CNT_W'(QDEPTH));
      // A younger completion during a mispredict is accepted but not stored.
      push[e] = i_eu_valid[e] && o_eu_ready[e] &&
                !(branch_mispredict &&
                  is_younger(in_cpl[e].rob_tag, i_rob_head, mispredict_rob_tag));
    end
  end

  // Round-robin arbitration starting at rr_q.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_EU; i++) begin
      if (!grant && head_valid[(int'(rr_q) + i) % NUM_EU]) begin
        grant  = 1'b1;
        winner = RR_W'((int'(rr_q) + i) % NUM_EU);
      end
    end
    // Flushed heads drain without a grant; the winner drains with one.
    for (int e = 0; e < NUM_EU; e++) begin
      pop[e] = (count_q[e] != '0) &&
               (!head_valid[e] || (grant && (winner == RR_W'(e))));
    end
    win_cpl = head_cpl[winner];
    // A younger winner is still popped but never reaches the bus.
    load    = grant && !(branch_mispredict &&
                         is_younger(win_cpl.rob_tag, i_rob_head, mispredict_rob_tag));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_EU; e++) begin
        slot_valid[e] <= '0;
        head_q[e]     <= '0;
        tail_q[e]     <= '0;
        count_q[e]    <= '0;
      end
      rr_q          <= '0;
      o_cdb_valid   <= 1'b0;
      o_cdb_prd     <= '0;
      o_cdb_rob_tag <= '0;
      o_cdb_result  <= '0;
    end else begin
      for (int e = 0; e < NUM_EU; e++) begin
        for (int q = 0; q < QDEPTH; q++) begin
          if (branch_mispredict && slot_valid[e][q] &&
              is_younger(slot_data[e][q].rob_tag, i_rob_head, mispredict_rob_tag)) begin
            slot_valid[e][q] <= 1'b0;
          end
        end
        if (pop[e]) begin
          slot_valid[e][head_q[e]] <= 1'b0;
          head_q[e]                <= ptr_inc(head_q[e]);
        end
        // Tail slot is always free when pushing, so it never collides with
        // the head clear above.
        if (push[e]) begin
          slot_valid[e][tail_q[e]] <= 1'b1;
          tail_q[e]                <= ptr_inc(tail_q[e]);
        end
        count_q[e] <= count_q[e] + CNT_W'(push[e]) - CNT_W'(pop[e]);
      end

      if (grant) begin
        rr_q <= (winner == RR_W'(NUM_EU - 1)) ? '0 : winner + RR_W'(1);
      end

      if (load) begin
        o_cdb_valid   <= 1'b1;
        o_cdb_prd     <= win_cpl.prd;
        o_cdb_rob_tag <= win_cpl.rob_tag;
        o_cdb_result  <= win_cpl.result;
      end else begin
        o_cdb_valid   <= 1'b0;
        o_cdb_prd     <= '0;
        o_cdb_rob_tag <= '0;
        o_cdb_result  <= '0;
      end
    end
  end

  // NOTE: the payload array has no reset; slot_valid and count_q already mark
  // every slot empty, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_EU; e++) begin
      if (push[e]) begin
        slot_data[e][tail_q[e]] <= in_cpl[e];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed bench for cdb_arbiter (PREG_WIDTH=7, ROB_WIDTH=4, NUM_EU=3,
// QDEPTH=2). Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  typedef struct packed {
    logic [6:0]  prd;
    logic [3:0]  tag;
    logic [31:0] result;
  } pkt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  eu_valid;
  logic [20:0] eu_prd;
  logic [11:0] eu_rob_tag;
  logic [95:0] eu_result;
  logic [2:0]  eu_ready;
  logic        cdb_valid;
  logic [6:0]  cdb_prd;
  logic [3:0]  cdb_rob_tag;
  logic [31:0] cdb_result;
  logic [3:0]  rob_head;
  logic        branch_mispredict;
  logic [3:0]  mispredict_rob_tag;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_in    = 0;
  int   n_out   = 0;
  int   seq     = 0;
  logic seen_ready1_low;
  pkt_t sb[$];

  always #5 clk = ~clk;

  cdb_arbiter #(
    .PREG_WIDTH(7), .ROB_WIDTH(4), .NUM_EU(3), .QDEPTH(2)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_eu_valid         (eu_valid),
    .i_eu_prd           (eu_prd),
    .i_eu_rob_tag       (eu_rob_tag),
    .i_eu_result        (eu_result),
    .o_eu_ready         (eu_ready),
    .o_cdb_valid        (cdb_valid),
    .o_cdb_prd          (cdb_prd),
    .o_cdb_rob_tag      (cdb_rob_tag),
    .o_cdb_result       (cdb_result),
    .i_rob_head         (rob_head),
    .branch_mispredict  (branch_mispredict),
    .mispredict_rob_tag (mispredict_rob_tag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int e, input logic [6:0] prd, input logic [3:0] tag,
                       input logic [31:0] res);
    eu_valid[e]           = 1'b1;
    eu_prd[e*7 +: 7]      = prd;
    eu_rob_tag[e*4 +: 4]  = tag;
    eu_result[e*32 +: 32] = res;
  endtask

  task automatic idle();
    eu_valid          = '0;
    branch_mispredict = 1'b0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Broadcast word packed as {prd, tag, result}.
  function automatic logic [63:0] bus();
    return {21'd0, cdb_prd, cdb_rob_tag, cdb_result};
  endfunction

  function automatic logic [63:0] pk(input logic [6:0] prd, input logic [3:0] tag,
                                     input logic [31:0] res);
    return {21'd0, prd, tag, res};
  endfunction

  // Scoreboard: each broadcast must be the oldest outstanding packet of its EU
  // (EU id carried in result[31:24]).
  task automatic observe();
    int   idx;
    logic found;
    if (cdb_valid === 1'b1) begin
      n_out++;
      idx   = -1;
      found = 1'b0;
      foreach (sb[i]) begin
        if (!found && sb[i].result[31:24] == cdb_result[31:24]) begin
          idx   = i;
          found = 1'b1;
        end
      end
      check("sb_hit", {63'd0, found}, 64'd1);
      if (found) begin
        check("sb_data", bus(), pk(sb[idx].prd, sb[idx].tag, sb[idx].result));
        sb.delete(idx);
      end
    end
  endtask

  // One cycle of saturating traffic: every ready EU presents a new packet.
  task automatic fill_step(input logic [2:0] mask);
    pkt_t p;
    for (int e = 0; e < 3; e++) begin
      if (mask[e] && eu_ready[e]) begin
        seq++;
        p.prd    = 7'(seq + 1);
        p.tag    = 4'(seq);
        p.result = {e[7:0], seq[23:0]};
        drive(e, p.prd, p.tag, p.result);
        sb.push_back(p);
        n_in++;
      end else begin
        eu_valid[e] = 1'b0;
      end
    end
    cyc();
    observe();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    eu_valid           = '0;
    eu_prd             = '0;
    eu_rob_tag         = '0;
    eu_result          = '0;
    rob_head           = '0;
    branch_mispredict  = 1'b0;
    mispredict_rob_tag = '0;
    seen_ready1_low    = 1'b0;

    // Reset state
    cyc();
    cyc();
    check("rst_valid", {63'd0, cdb_valid}, 64'd0);
    check("rst_bus", bus(), 64'd0);
    check("rst_ready", {61'd0, eu_ready}, 64'd7);
    reset = 1'b0;

    // 1: single completion, two edges of latency, one cycle wide
    drive(0, 7'd5, 4'd3, 32'hDEADBEEF);
    cyc();
    check("t1_lat_valid", {63'd0, cdb_valid}, 64'd0);
    check("t1_ready", {61'd0, eu_ready}, 64'd7);
    idle();
    cyc();
    check("t1_valid", {63'd0, cdb_valid}, 64'd1);
    check("t1_bus", bus(), pk(7'd5, 4'd3, 32'hDEADBEEF));
    cyc();
    check("t1_one_cycle", {63'd0, cdb_valid}, 64'd0);

    // 2: simultaneous triple from rr=0, then a second triple resumes at EU0
    do_reset();
    drive(0, 7'd10, 4'd4, 32'h1000_0000);
    drive(1, 7'd11, 4'd5, 32'h1100_0000);
    drive(2, 7'd12, 4'd6, 32'h1200_0000);
    cyc();
    idle();
    cyc();
    check("t2_eu0", bus(), pk(7'd10, 4'd4, 32'h1000_0000));
    cyc();
    check("t2_eu1", bus(), pk(7'd11, 4'd5, 32'h1100_0000));
    cyc();
    check("t2_eu2", bus(), pk(7'd12, 4'd6, 32'h1200_0000));
    drive(0, 7'd20, 4'd7, 32'h2000_0000);
    drive(1, 7'd21, 4'd8, 32'h2100_0000);
    drive(2, 7'd22, 4'd9, 32'h2200_0000);
    cyc();
    check("t2_gap", {63'd0, cdb_valid}, 64'd0);
    idle();
    cyc();
    check("t2b_eu0", bus(), pk(7'd20, 4'd7, 32'h2000_0000));
    cyc();
    check("t2b_eu1", bus(), pk(7'd21, 4'd8, 32'h2100_0000));
    cyc();
    check("t2b_eu2", bus(), pk(7'd22, 4'd9, 32'h2200_0000));

    // 3: saturating traffic; EU1 fills up, nothing lost or duplicated
    n_in  = 0;
    n_out = 0;
    fill_step(3'b111);
    fill_step(3'b111);
    check("t3_ready_after_fill", {61'd0, eu_ready}, 64'd1);
    for (int c = 0; c < 14; c++) begin
      if (eu_ready[1] === 1'b0) seen_ready1_low = 1'b1;
      fill_step(3'b111);
    end
    idle();
    for (int c = 0; c < 10; c++) begin
      cyc();
      observe();
    end
    check("t3_ready1_dropped", {63'd0, seen_ready1_low}, 64'd1);
    check("t3_in_eq_out", 64'(n_out), 64'(n_in));
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    check("t3_ready_idle", {61'd0, eu_ready}, 64'd7);

    // 4: head=14, buffered tags 15, 0, 2; mispredict on tag 0 flushes tag 2
    do_reset();
    rob_head = 4'd14;
    drive(0, 7'd30, 4'd15, 32'h3000_0000);
    drive(1, 7'd31, 4'd0,  32'h3100_0000);
    drive(2, 7'd32, 4'd2,  32'h3200_0000);
    cyc();
    idle();
    branch_mispredict  = 1'b1;
    mispredict_rob_tag = 4'd0;
    cyc();
    branch_mispredict = 1'b0;
    check("t4_tag15", bus(), pk(7'd30, 4'd15, 32'h3000_0000));
    check("t4_tag15_valid", {63'd0, cdb_valid}, 64'd1);
    cyc();
    check("t4_tag0", bus(), pk(7'd31, 4'd0, 32'h3100_0000));
    cyc();
    check("t4_no_tag2", {63'd0, cdb_valid}, 64'd0);
    check("t4_ready", {61'd0, eu_ready}, 64'd7);
    cyc();
    check("t4_no_tag2_late", {63'd0, cdb_valid}, 64'd0);

    // 5: younger incoming EU2 accepted and dropped, older EU0 broadcast
    drive(0, 7'd40, 4'd15, 32'h4000_0000);
    drive(2, 7'd42, 4'd3,  32'h4200_0000);
    branch_mispredict  = 1'b1;
    mispredict_rob_tag = 4'd0;
    #1;
    check("t5_ready_in", {61'd0, eu_ready}, 64'd7);
    cyc();
    idle();
    check("t5_idle", {63'd0, cdb_valid}, 64'd0);
    check("t5_ready_after", {61'd0, eu_ready}, 64'd7);
    cyc();
    check("t5_older", bus(), pk(7'd40, 4'd15, 32'h4000_0000));
    check("t5_older_valid", {63'd0, cdb_valid}, 64'd1);
    cyc();
    check("t5_no_younger", {63'd0, cdb_valid}, 64'd0);
    cyc();
    check("t5_no_younger_late", {63'd0, cdb_valid}, 64'd0);

    // 6: async reset mid-burst
    rob_head = 4'd0;
    for (int c = 0; c < 5; c++) fill_step(3'b111);
    check("t6_busy", {63'd0, cdb_valid}, 64'd1);
    #2;
    reset = 1'b1;
    idle();
    #1;
    check("t6_async_valid", {63'd0, cdb_valid}, 64'd0);
    check("t6_async_bus", bus(), 64'd0);
    check("t6_async_ready", {61'd0, eu_ready}, 64'd7);
    cyc();
    reset = 1'b0;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("t6_no_stale", {63'd0, cdb_valid}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
